// File: rtl/snake_pkg.sv
// Shared constants for the snake game: direction, game state and collision codes.
// The drawing and collision blocks import the same package so the encodings agree.
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_IDLE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    GS_START     = 2'b00,
    GS_PLAY      = 2'b01,
    GS_GAME_OVER = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    COL_NONE  = 2'b00,
    COL_WALL  = 2'b01,
    COL_APPLE = 2'b10,
    COL_SELF  = 2'b11
  } collision_t;

  // Button indices into the debounced press vector.
  localparam int NUM_BUTTONS = 5;
  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_LEFT    = 2;
  localparam int BTN_RIGHT   = 3;
  localparam int BTN_START   = 4;

  // True when a and b point in exactly opposite directions.
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return ((a == DIR_UP)    && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN)  && (b == DIR_UP))    ||
           ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
           ((a == DIR_RIGHT) && (b == DIR_LEFT));
  endfunction

endpackage

// File: rtl/snake_control_button_debounce.sv
// One button conditioner: 2-FF synchroniser, stable-level counter and a
// single-cycle press pulse on each accepted rising level.
module button_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic [1:0]  sync_reg;
  logic [15:0] count_reg;
  logic        level_reg;
  logic        press_reg;

  // Bring the raw asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) sync_reg <= 2'b00;
    else       sync_reg <= {sync_reg[0], btn};
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
  // the press pulse is registered on the same edge the level flips to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 16'd0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        count_reg <= 16'd0;
      end else if (count_reg == DEBOUNCE_CYCLES - 16'd1) begin
        count_reg <= 16'd0;
        level_reg <= sync_reg[1];
        press_reg <= sync_reg[1];
      end else begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/snake_control.sv
// Game control for the snake: debounced buttons, game-state FSM, step timing
// from the frame tick, direction commit and apple score.
module snake_control
  import snake_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [3:0]  FRAMES_PER_STEP = 4'd6,
  parameter logic [7:0]  GAMEOVER_FRAMES = 8'd120,
  parameter int          SCORE_BITS      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_start,
  input  logic                  frame_tick,
  input  logic [1:0]            collision,
  output logic [2:0]            direction,
  output logic                  update,
  output logic [1:0]            game_state,
  output logic [SCORE_BITS-1:0] score
);

  localparam logic [SCORE_BITS-1:0] SCORE_MAX = {SCORE_BITS{1'b1}};

  logic [NUM_BUTTONS-1:0] btn_raw;
  logic [NUM_BUTTONS-1:0] btn_press;

  assign btn_raw = {btn_start, btn_right, btn_left, btn_down, btn_up};

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_debounce
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .btn  (btn_raw[gi]),
      .press(btn_press[gi])
    );
  end

  game_state_t           state_reg, state_next;
  dir_t                  direction_reg, direction_next;
  dir_t                  pending_dir_reg, pending_dir_next;
  dir_t                  press_dir;
  logic [3:0]            frame_cnt_reg, frame_cnt_next;
  logic [7:0]            hold_cnt_reg, hold_cnt_next;
  logic [SCORE_BITS-1:0] score_reg, score_next;
  logic                  update_reg, update_next;
  logic                  apple_prev_reg, apple_prev_next;
  logic                  apple_now;

  // Resolve simultaneous direction presses, UP highest priority.
  always_comb begin
    press_dir = DIR_IDLE;
    if      (btn_press[BTN_UP])    press_dir = DIR_UP;
    else if (btn_press[BTN_DOWN])  press_dir = DIR_DOWN;
    else if (btn_press[BTN_LEFT])  press_dir = DIR_LEFT;
    else if (btn_press[BTN_RIGHT]) press_dir = DIR_RIGHT;
  end

  assign apple_now = (collision == COL_APPLE);

  // Next-state and datapath: start/play/game-over sequencing, step timing and scoring.
  always_comb begin
    state_next       = state_reg;
    direction_next   = direction_reg;
    pending_dir_next = pending_dir_reg;
    frame_cnt_next   = frame_cnt_reg;
    hold_cnt_next    = hold_cnt_reg;
    score_next       = score_reg;
    update_next      = 1'b0;
    apple_prev_next  = 1'b0;
    case (state_reg)
      GS_START: begin
        direction_next = DIR_IDLE;
        if (btn_press[BTN_START]) begin
          state_next       = GS_PLAY;
          score_next       = '0;
          frame_cnt_next   = 4'd0;
          pending_dir_next = DIR_IDLE;
        end
      end
      GS_PLAY: begin
        // A reversal would drive the snake into itself, so it is dropped.
        if ((press_dir != DIR_IDLE) &&
            ((direction_reg == DIR_IDLE) || !is_opposite(press_dir, direction_reg)))
          pending_dir_next = press_dir;
        apple_prev_next = apple_now;
        if (apple_now && !apple_prev_reg && (score_reg != SCORE_MAX))
          score_next = score_reg + SCORE_BITS'(1);
        if ((collision == COL_WALL) || (collision == COL_SELF)) begin
          state_next     = GS_GAME_OVER;
          direction_next = DIR_IDLE;
          hold_cnt_next  = 8'd0;
        end else if (frame_tick) begin
          if (frame_cnt_reg == FRAMES_PER_STEP - 4'd1) begin
            frame_cnt_next = 4'd0;
            update_next    = 1'b1;
            direction_next = pending_dir_reg;
          end else begin
            frame_cnt_next = frame_cnt_reg + 4'd1;
          end
        end
      end
      GS_GAME_OVER: begin
        direction_next = DIR_IDLE;
        if (frame_tick) begin
          if (hold_cnt_reg == GAMEOVER_FRAMES - 8'd1) begin
            state_next    = GS_START;
            hold_cnt_next = 8'd0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 8'd1;
          end
        end
      end
      default: begin
        state_next     = GS_START;
        direction_next = DIR_IDLE;
      end
    endcase
  end

  // Game-state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= GS_START;
    else       state_reg <= state_next;
  end

  // Datapath registers: direction, pending press, counters, score and strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      direction_reg   <= DIR_IDLE;
      pending_dir_reg <= DIR_IDLE;
      frame_cnt_reg   <= 4'd0;
      hold_cnt_reg    <= 8'd0;
      score_reg       <= '0;
      update_reg      <= 1'b0;
      apple_prev_reg  <= 1'b0;
    end else begin
      direction_reg   <= direction_next;
      pending_dir_reg <= pending_dir_next;
      frame_cnt_reg   <= frame_cnt_next;
      hold_cnt_reg    <= hold_cnt_next;
      score_reg       <= score_next;
      update_reg      <= update_next;
      apple_prev_reg  <= apple_prev_next;
    end
  end

  assign direction  = direction_reg;
  assign update     = update_reg;
  assign game_state = state_reg;
  assign score      = score_reg;

endmodule

// File: tb/tb_snake_control.sv
// Directed bench for snake_control with short debounce/step/hold parameters
// and a frame tick every 10 cycles.
module tb_snake_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] collision = 2'b00;
  logic [2:0] direction;
  logic       update;
  logic [1:0] game_state;
  logic [7:0] score;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  snake_control #(
    .DEBOUNCE_CYCLES(16'd4),
    .FRAMES_PER_STEP(4'd2),
    .GAMEOVER_FRAMES(8'd3),
    .SCORE_BITS     (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_start (btn_start),
    .frame_tick(frame_tick),
    .collision (collision),
    .direction (direction),
    .update    (update),
    .game_state(game_state),
    .score     (score)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    frame_tick = (cyc % 10 == 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_update(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((update !== 1'b1) && (n < 60));
    chk(tag, {31'd0, update}, 32'd1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int  ft;
    int  n;
    logic ftp;

    // 1. reset and glitch rejection
    ticks(3);
    chk("rst_state", {30'd0, game_state}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rel_state", {30'd0, game_state}, 32'd0);
    chk("rel_dir", {29'd0, direction}, 32'd0);
    chk("rel_update", {31'd0, update}, 32'd0);
    chk("rel_score", {24'd0, score}, 32'd0);
    btn_start = 1'b1;
    ticks(3);
    btn_start = 1'b0;
    ticks(10);
    chk("glitch_state", {30'd0, game_state}, 32'd0);

    // 2. start press: PLAY exactly 7 cycles after the raw edge
    btn_start = 1'b1;
    ticks(6);
    chk("start_lat6", {30'd0, game_state}, 32'd0);
    tick();
    chk("start_lat7", {30'd0, game_state}, 32'd1);
    ticks(3);
    btn_start = 1'b0;
    // frame ticks sampled at/after the entry edge do not count; the 2nd later one steps
    ft = 0;
    for (int i = 0; i < 60; i++) begin
      ftp = frame_tick;
      tick();
      if (ftp) ft++;
      if (update === 1'b1) break;
    end
    chk("first_update", {31'd0, update}, 32'd1);
    chk("first_update_ticks", ft, 32'd2);
    chk("first_update_dir", {29'd0, direction}, 32'd0);
    tick();
    chk("update_one_cycle", {31'd0, update}, 32'd0);

    // 3. direction commit, reversal dropped, later UP accepted
    btn_right = 1'b1;
    ticks(7);
    btn_right = 1'b0;
    wait_update("right_update");
    chk("right_dir", {29'd0, direction}, 32'd4);
    btn_left = 1'b1;
    ticks(7);
    btn_left = 1'b0;
    wait_update("left_update");
    chk("left_dropped_dir", {29'd0, direction}, 32'd4);
    btn_up = 1'b1;
    ticks(7);
    btn_up = 1'b0;
    wait_update("up_update");
    chk("up_dir", {29'd0, direction}, 32'd1);

    // 4. apple scoring: one point per rising edge, saturating
    for (int r = 0; r < 2; r++) begin
      collision = 2'b10;
      ticks(5);
      collision = 2'b00;
      ticks(3);
    end
    chk("score_two", {24'd0, score}, 32'd2);
    chk("apple_keeps_play", {30'd0, game_state}, 32'd1);
    for (int p = 0; p < 256; p++) begin
      collision = 2'b10;
      tick();
      collision = 2'b00;
      tick();
    end
    chk("score_sat", {24'd0, score}, 32'd255);
    collision = 2'b10;
    tick();
    collision = 2'b00;
    tick();
    chk("score_sat_hold", {24'd0, score}, 32'd255);

    // 5. wall hit on a step-due edge, then the game-over hold
    wait_update("pre_wall_update");
    n = 0;
    while ((frame_tick !== 1'b1) && (n < 20)) begin tick(); n++; end
    tick();
    n = 0;
    while ((frame_tick !== 1'b1) && (n < 20)) begin tick(); n++; end
    collision = 2'b01;
    tick();
    collision = 2'b00;
    chk("wall_state", {30'd0, game_state}, 32'd3);
    chk("wall_no_update", {31'd0, update}, 32'd0);
    chk("wall_dir", {29'd0, direction}, 32'd0);
    tick();
    chk("wall_no_late_update", {31'd0, update}, 32'd0);
    chk("go_score_held", {24'd0, score}, 32'd255);
    ft = 0;
    for (int i = 0; i < 80; i++) begin
      btn_start = (i < 8);
      ftp = frame_tick;
      tick();
      if (ftp) ft++;
      if (i == 8) chk("go_start_ignored", {30'd0, game_state}, 32'd3);
      if (game_state === 2'b00) break;
    end
    btn_start = 1'b0;
    chk("go_back_start", {30'd0, game_state}, 32'd0);
    chk("go_hold_ticks", ft, 32'd3);
    ticks(10);
    chk("go_press_consumed", {30'd0, game_state}, 32'd0);

    // 6. new game, then reset mid-PLAY with btn_up held
    btn_start = 1'b1;
    ticks(7);
    btn_start = 1'b0;
    chk("g2_play", {30'd0, game_state}, 32'd1);
    chk("g2_score_clear", {24'd0, score}, 32'd0);
    collision = 2'b10;
    tick();
    collision = 2'b00;
    tick();
    chk("g2_score", {24'd0, score}, 32'd1);
    wait_update("g2_update");
    chk("g2_pending_cleared", {29'd0, direction}, 32'd0);
    btn_up = 1'b1;
    ticks(2);
    reset = 1'b1;
    tick();
    chk("mid_rst_state", {30'd0, game_state}, 32'd0);
    chk("mid_rst_dir", {29'd0, direction}, 32'd0);
    chk("mid_rst_update", {31'd0, update}, 32'd0);
    chk("mid_rst_score", {24'd0, score}, 32'd0);
    reset = 1'b0;
    btn_start = 1'b1;
    ticks(6);
    chk("g3_lat6", {30'd0, game_state}, 32'd0);
    tick();
    chk("g3_lat7", {30'd0, game_state}, 32'd1);
    btn_start = 1'b0;
    wait_update("g3_update");
    chk("g3_up_in_start_ignored", {29'd0, direction}, 32'd0);
    btn_up = 1'b0;
    ticks(8);
    btn_up = 1'b1;
    ticks(7);
    btn_up = 1'b0;
    wait_update("g3_up_update");
    chk("g3_up_dir", {29'd0, direction}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_control.md
Name: snake_control

Overview:
Game-control stage directly upstream of the snake drawing block. It debounces the five player buttons and runs the game-state FSM, driving direction, update and game_state into the drawing block. It also consumes the collision code returned by the collision logic and keeps the apple score. All step timing is derived from a one-cycle-per-frame tick supplied by the VGA timing block.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, clock cycles a synchronised button level must stay stable before it is accepted
FRAMES_PER_STEP, 4'd6, frame ticks between snake moves (update pulses) while in PLAY
GAMEOVER_FRAMES, 8'd120, frame ticks GAME_OVER is held before returning to START
SCORE_BITS, 8, width of the score counter

Ports:
clk  in  1  system clock, the single clock domain
reset  in  1  synchronous, active-high reset
btn_up, btn_down, btn_left, btn_right, btn_start  in  1 each  raw asynchronous buttons, active-high
frame_tick  in  1  one-cycle pulse per video frame
collision  in  2  00 none, 01 wall, 10 apple collected, 11 self-hit
direction  out  3  0 IDLE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT
update  out  1  one-cycle move strobe
game_state  out  2  00 START, 01 PLAY, 11 GAME_OVER
score  out  SCORE_BITS  apples collected this game

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values: game_state=START, direction=IDLE, update=0, score=0. All debounce counters, synchronisers, the frame counter, pending_dir and hold counter are cleared.
- Reset mid-game behaves the same as power-up reset. It takes effect at the next edge.
- Buttons: each button passes through a 2-FF synchroniser, then a stable counter. The accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples.
- A press is the rising edge of the accepted level, a 1-cycle internal pulse. Total latency from a stable raw edge is 2 + DEBOUNCE_CYCLES + 1 cycles.
- pending_dir holds the latest accepted direction press.
  - Simultaneous presses use priority UP > DOWN > LEFT > RIGHT.
  - A press opposite to the committed direction is dropped (UP/DOWN and LEFT/RIGHT are opposites).
  - Any press is accepted while the committed direction is IDLE.
- FSM:
  - START: waits for a start press, then goes to PLAY on the next edge. Direction presses are ignored. On entry to PLAY: score=0, frame counter=0, direction=IDLE, pending_dir=IDLE.
  - PLAY: frame counter increments on frame_tick. When the counter is at FRAMES_PER_STEP-1 and a frame_tick arrives, the counter wraps to 0. On that same edge, update becomes 1 for exactly one cycle and direction loads pending_dir. As a result, direction is already new during the update-high cycle.
  - PLAY, collision 01 or 11: goes to GAME_OVER on the next edge. No update is issued on that edge even if a step is due.
  - PLAY, collision 10: score increments once per rising edge of (collision==10), saturating at all-ones.
  - GAME_OVER: update=0 and direction=IDLE. A hold counter counts GAMEOVER_FRAMES frame ticks, then the FSM goes to START. Start presses and collision are ignored during the hold. score is held so it can be displayed.
- collision is ignored outside PLAY.
- frame_tick is ignored in START.
- update is never asserted outside PLAY and is never high on two consecutive cycles.
- If a start press and a frame_tick occur together in START, only the state transition happens. The first update needs a further FRAMES_PER_STEP ticks.

Decomposition:
- Shared package snake_pkg holds the direction codes (IDLE..RIGHT), the game_state codes (START/PLAY/GAME_OVER) and the collision codes (NONE/WALL/APPLE/SELF). The drawing and collision blocks import the same constants.
- One sub-module, button_debounce: synchroniser plus stable counter plus rising-edge pulse, parameterised by DEBOUNCE_CYCLES. It is instantiated five times.

Test Plan:
Test parameters for all scenarios: DEBOUNCE_CYCLES=4, FRAMES_PER_STEP=2, GAMEOVER_FRAMES=3, frame_tick every 10 cycles.
1. reset held 3 cycles, then released -> game_state=00, direction=0, update=0, score=0. A 3-cycle glitch on btn_start causes no state change.
2. btn_start held 10 cycles -> game_state=01 exactly 7 cycles after the raw edge. The first update pulse arrives on the 2nd frame_tick after entry.
3. In PLAY, press RIGHT, then LEFT before the next step -> at the update edge direction=4. LEFT is dropped. A later UP gives direction=1 at the following update.
4. In PLAY, collision=10 held 5 cycles, repeated twice -> score=2, not 10. Apply collision=10 together with score preset near saturation via 256 pulses (SCORE_BITS=8) -> score=255 and stays there.
5. In PLAY with a step due on the same edge, collision=01 -> game_state=11, no update pulse, direction=0. After 3 frame ticks, game_state=00. A start press during the hold is ignored.
6. reset asserted mid-PLAY while btn_up is held -> next edge gives all outputs at reset values. btn_up must re-debounce the full 4 cycles before it can have any effect.
